// File: rtl/status_reg_if.sv
// -----------------------------------------------------------------------------
// status_reg_if
// Bundles the signals between the CPU control unit and the 6502-style
// processor status register.
//
// Signals (direction seen from the status register, i.e. the slave modport):
//   alu_out   in  8  ALU result (N/Z source, Z source for BIT)
//   alu_c     in  1  ALU carry out
//   alu_v     in  1  ALU overflow
//   bus_in    in  8  data bus byte (PLP/RTI pull, BIT operand)
//   upd_nz    in  1  load N/Z from ALU
//   upd_c     in  1  load C from ALU
//   upd_v     in  1  load V from ALU
//   bit_op    in  1  BIT instruction flag update
//   plp       in  1  load P from bus_in
//   int_entry in  1  interrupt/BRK entry (sets I)
//   set_op    in  1  explicit flag set/clear (CLC/SEC/CLI/SEI/CLD/SED/CLV)
//   set_sel   in  2  target flag: 0=C, 1=I, 2=D, 3=V
//   set_val   in  1  value written by set_op
//   push_brk  in  1  B bit value presented on p_push
//   irq_n     in  1  asynchronous IRQ line, active-low (level)
//   nmi_n     in  1  asynchronous NMI line, falling-edge triggered
//   nmi_ack   in  1  clear the pending NMI
//   p_out     out 8  flags NV11DIZC
//   p_push    out 8  flags NV1BDIZC, B = push_brk
//   carry     out 1  C flag to the ALU carry-in
//   decimal   out 1  D flag
//   irq_req   out 1  masked IRQ request (registered)
//   nmi_req   out 1  pending NMI
//
// There is no valid/ready handshake here: every control input is a
// single-cycle qualifier sampled on the rising clock edge, and the outputs
// are always valid.
// -----------------------------------------------------------------------------
interface status_reg_if;
  logic [7:0] alu_out;
  logic       alu_c;
  logic       alu_v;
  logic [7:0] bus_in;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       bit_op;
  logic       plp;
  logic       int_entry;
  logic       set_op;
  logic [1:0] set_sel;
  logic       set_val;
  logic       push_brk;
  logic       irq_n;
  logic       nmi_n;
  logic       nmi_ack;
  logic [7:0] p_out;
  logic [7:0] p_push;
  logic       carry;
  logic       decimal;
  logic       irq_req;
  logic       nmi_req;

  // Control unit side.
  modport master (
    output alu_out, alu_c, alu_v, bus_in,
    output upd_nz, upd_c, upd_v, bit_op, plp, int_entry,
    output set_op, set_sel, set_val, push_brk,
    output irq_n, nmi_n, nmi_ack,
    input  p_out, p_push, carry, decimal, irq_req, nmi_req
  );

  // Status register side.
  modport slave (
    input  alu_out, alu_c, alu_v, bus_in,
    input  upd_nz, upd_c, upd_v, bit_op, plp, int_entry,
    input  set_op, set_sel, set_val, push_brk,
    input  irq_n, nmi_n, nmi_ack,
    output p_out, p_push, carry, decimal, irq_req, nmi_req
  );
endinterface

// File: rtl/status_reg.sv
// -----------------------------------------------------------------------------
// status_reg
// 6502-style processor status register (P) with interrupt request
// conditioning.
//
// Ports:
//   clk    in   1  system clock, all state updates on the rising edge
//   rst_n  in   1  asynchronous active-low reset
//   sr_if  slave    status_reg_if bundle (ALU/bus inputs, flag update
//                   controls, IRQ/NMI lines, P outputs, interrupt requests)
//
// Flag update priority, lowest to highest, applied per flag:
//   upd_nz / upd_c / upd_v  ->  bit_op (N,V,Z)  ->  set_op (selected flag)
//   ->  plp (all six flags)  ->  int_entry (I only)
// A flag with no active update holds its value.
//
// irq_n and nmi_n each pass a two-flop synchronizer. irq_req is registered
// from the synchronized level masked by the I flag as it was before the
// current edge, so CLI/SEI reach irq_req one cycle late. A falling edge of
// the synchronized NMI sets a sticky pending bit; nmi_ack clears it unless a
// new falling edge is seen in the same cycle.
// -----------------------------------------------------------------------------
module status_reg (
  input  logic         clk,
  input  logic         rst_n,
  status_reg_if.slave  sr_if
);

  // set_sel encoding
  localparam logic [1:0] SEL_C = 2'd0;
  localparam logic [1:0] SEL_I = 2'd1;
  localparam logic [1:0] SEL_D = 2'd2;
  localparam logic [1:0] SEL_V = 2'd3;

  // ---------------------------------------------------------------------------
  // Flag registers
  // ---------------------------------------------------------------------------
  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;

  logic alu_zero;
  assign alu_zero = (sr_if.alu_out == 8'h00);

  // Later assignments win, so the statement order below is the priority.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;

    if (sr_if.upd_nz) begin
      n_d = sr_if.alu_out[7];
      z_d = alu_zero;
    end
    if (sr_if.upd_c) c_d = sr_if.alu_c;
    if (sr_if.upd_v) v_d = sr_if.alu_v;

    // BIT: N and V come from the memory operand, Z from the AND result.
    if (sr_if.bit_op) begin
      n_d = sr_if.bus_in[7];
      v_d = sr_if.bus_in[6];
      z_d = alu_zero;
    end

    if (sr_if.set_op) begin
      case (sr_if.set_sel)
        SEL_C:   c_d = sr_if.set_val;
        SEL_I:   i_d = sr_if.set_val;
        SEL_D:   d_d = sr_if.set_val;
        SEL_V:   v_d = sr_if.set_val;
        default: ;
      endcase
    end

    // Pulled byte: bits 5 (always 1) and 4 (B, not a real flag) are dropped.
    if (sr_if.plp) begin
      n_d = sr_if.bus_in[7];
      v_d = sr_if.bus_in[6];
      d_d = sr_if.bus_in[3];
      i_d = sr_if.bus_in[2];
      z_d = sr_if.bus_in[1];
      c_d = sr_if.bus_in[0];
    end

    // Interrupt entry masks further IRQs; D is deliberately left alone.
    if (sr_if.int_entry) i_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
      d_q <= 1'b0;
      i_q <= 1'b1;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  // Outputs are taken straight from the flag registers.
  assign sr_if.p_out   = {n_q, v_q, 1'b1, 1'b1,           d_q, i_q, z_q, c_q};
  assign sr_if.p_push  = {n_q, v_q, 1'b1, sr_if.push_brk, d_q, i_q, z_q, c_q};
  assign sr_if.carry   = c_q;
  assign sr_if.decimal = d_q;

  // ---------------------------------------------------------------------------
  // IRQ: synchronize, then mask with the pre-edge I flag
  // ---------------------------------------------------------------------------
  logic irq_s1_q, irq_s2_q;
  logic irq_req_q, irq_req_d;

  assign irq_req_d = ~irq_s2_q & ~i_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1_q  <= 1'b1;
      irq_s2_q  <= 1'b1;
      irq_req_q <= 1'b0;
    end else begin
      irq_s1_q  <= sr_if.irq_n;
      irq_s2_q  <= irq_s1_q;
      irq_req_q <= irq_req_d;
    end
  end

  assign sr_if.irq_req = irq_req_q;

  // ---------------------------------------------------------------------------
  // NMI: synchronize, detect the 1->0 transition, hold it until acknowledged
  // ---------------------------------------------------------------------------
  logic nmi_s1_q, nmi_s2_q, nmi_prev_q;
  logic nmi_fall;
  logic nmi_pending_q, nmi_pending_d;

  // A level held low produces exactly one edge: prev follows s2.
  assign nmi_fall = nmi_prev_q & ~nmi_s2_q;

  always_comb begin
    nmi_pending_d = nmi_pending_q;
    if (sr_if.nmi_ack) nmi_pending_d = 1'b0;
    // A fresh edge beats a simultaneous acknowledge so it is not lost.
    if (nmi_fall)      nmi_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_s1_q      <= 1'b1;
      nmi_s2_q      <= 1'b1;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      nmi_s1_q      <= sr_if.nmi_n;
      nmi_s2_q      <= nmi_s1_q;
      nmi_prev_q    <= nmi_s2_q;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign sr_if.nmi_req = nmi_pending_q;

endmodule

// File: tb/tb_status_reg.sv
// -----------------------------------------------------------------------------
// tb_status_reg
// Directed test of status_reg. Expected values are hand-computed constants.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_status_reg;

  logic clk;
  logic rst_n;

  status_reg_if sr_if ();

  status_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sr_if (sr_if.slave)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt;
  int miss_cnt;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check_val(input string tag, input logic [7:0] got,
                           input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    sr_if.upd_nz    = 1'b0;
    sr_if.upd_c     = 1'b0;
    sr_if.upd_v     = 1'b0;
    sr_if.bit_op    = 1'b0;
    sr_if.plp       = 1'b0;
    sr_if.int_entry = 1'b0;
    sr_if.set_op    = 1'b0;
    sr_if.set_sel   = 2'd0;
    sr_if.set_val   = 1'b0;
    sr_if.nmi_ack   = 1'b0;
  endtask

  task automatic do_set(input logic [1:0] sel, input logic val);
    sr_if.set_op  = 1'b1;
    sr_if.set_sel = sel;
    sr_if.set_val = val;
  endtask

  task automatic do_plp(input logic [7:0] b);
    sr_if.plp    = 1'b1;
    sr_if.bus_in = b;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    clear_ctl();
    sr_if.alu_out  = 8'h00;
    sr_if.alu_c    = 1'b0;
    sr_if.alu_v    = 1'b0;
    sr_if.bus_in   = 8'h00;
    sr_if.push_brk = 1'b0;
    sr_if.irq_n    = 1'b1;
    sr_if.nmi_n    = 1'b1;
    rst_n          = 1'b0;
    #12;

    // Reset values
    check_val("rst_p_out",   sr_if.p_out,   8'h34);
    check_val("rst_p_push",  sr_if.p_push,  8'h24);
    check_val("rst_carry",   sr_if.carry,   8'h00);
    check_val("rst_decimal", sr_if.decimal, 8'h00);
    check_val("rst_irq_req", sr_if.irq_req, 8'h00);
    check_val("rst_nmi_req", sr_if.nmi_req, 8'h00);

    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("idle_p_out", sr_if.p_out,   8'h34);
      check_val("idle_irq",   sr_if.irq_req, 8'h00);
      check_val("idle_nmi",   sr_if.nmi_req, 8'h00);
    end

    // ALU updates: all three at once, then N/Z only
    sr_if.alu_out = 8'h00; sr_if.alu_c = 1'b1; sr_if.alu_v = 1'b1;
    sr_if.upd_nz = 1'b1; sr_if.upd_c = 1'b1; sr_if.upd_v = 1'b1;
    step(); clear_ctl();
    check_val("alu_all",    sr_if.p_out, 8'h77);
    check_val("alu_carry",  sr_if.carry, 8'h01);
    sr_if.alu_out = 8'h80; sr_if.alu_c = 1'b0; sr_if.alu_v = 1'b0;
    sr_if.upd_nz = 1'b1;
    step(); clear_ctl();
    check_val("alu_nz_only", sr_if.p_out, 8'hF5);
    step();
    check_val("hold",        sr_if.p_out, 8'hF5);

    // PLP of all ones, B presentation on p_push
    do_plp(8'hFF);
    step(); clear_ctl();
    check_val("plp_ff_out",   sr_if.p_out,   8'hFF);
    check_val("plp_ff_push0", sr_if.p_push,  8'hEF);
    check_val("plp_ff_dec",   sr_if.decimal, 8'h01);
    sr_if.push_brk = 1'b1; #1;
    check_val("plp_ff_push1", sr_if.p_push,  8'hFF);
    sr_if.push_brk = 1'b0;

    // int_entry beats plp on I
    do_plp(8'h00); sr_if.int_entry = 1'b1;
    step(); clear_ctl();
    check_val("plp_int", sr_if.p_out, 8'h34);

    // SED, then int_entry with CLI and a carry update: I stays set, D kept
    do_set(2'd2, 1'b1);
    step(); clear_ctl();
    check_val("sed", sr_if.p_out, 8'h3C);
    sr_if.int_entry = 1'b1; do_set(2'd1, 1'b0);
    sr_if.upd_c = 1'b1; sr_if.alu_c = 1'b1;
    step(); clear_ctl();
    check_val("int_vs_cli", sr_if.p_out, 8'h3D);

    // set_op beats upd_c on C
    sr_if.upd_c = 1'b1; sr_if.alu_c = 1'b1; do_set(2'd0, 1'b0);
    step(); clear_ctl();
    check_val("clc_vs_upd", sr_if.p_out, 8'h3C);

    // plp beats set_op; bus bits 5:4 ignored
    do_plp(8'h30); do_set(2'd2, 1'b1);
    step(); clear_ctl();
    check_val("plp_vs_sed", sr_if.p_out, 8'h30);

    // BIT with SEC in the same cycle, from 8'h34; BIT also beats upd_v
    do_plp(8'h04);
    step(); clear_ctl();
    check_val("plp_04", sr_if.p_out, 8'h34);
    sr_if.bit_op = 1'b1; sr_if.bus_in = 8'hC0; sr_if.alu_out = 8'h00;
    sr_if.upd_v = 1'b1; sr_if.alu_v = 1'b0;
    do_set(2'd0, 1'b1);
    step(); clear_ctl();
    check_val("bit_sec", sr_if.p_out, 8'hF7);

    // IRQ: clear I, drop irq_n, request appears on the third edge
    do_plp(8'h00);
    step(); clear_ctl();
    check_val("irq_cli", sr_if.p_out, 8'h30);
    sr_if.irq_n = 1'b0;
    step(); check_val("irq_e1", sr_if.irq_req, 8'h00);
    step(); check_val("irq_e2", sr_if.irq_req, 8'h00);
    step(); check_val("irq_e3", sr_if.irq_req, 8'h01);
    do_set(2'd1, 1'b1);
    step(); clear_ctl();
    check_val("sei_p",       sr_if.p_out,   8'h34);
    check_val("sei_irq_lag", sr_if.irq_req, 8'h01);
    step();
    check_val("sei_irq_off", sr_if.irq_req, 8'h00);
    sr_if.irq_n = 1'b1;

    // Reset in the middle of an update discards it
    do_plp(8'hFF); sr_if.upd_c = 1'b1; sr_if.alu_c = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_val("mid_rst_async", sr_if.p_out, 8'h34);
    @(posedge clk); #1;
    clear_ctl();
    rst_n = 1'b1;
    step();
    check_val("mid_rst_after", sr_if.p_out, 8'h34);

    // NMI: fall, one pending event, ack, re-arm
    sr_if.nmi_n = 1'b0;
    step(); check_val("nmi_e1", sr_if.nmi_req, 8'h00);
    step(); check_val("nmi_e2", sr_if.nmi_req, 8'h00);
    step(); check_val("nmi_e3", sr_if.nmi_req, 8'h01);
    for (int k = 0; k < 3; k++) begin
      step(); check_val("nmi_hold", sr_if.nmi_req, 8'h01);
    end
    sr_if.nmi_ack = 1'b1;
    step(); sr_if.nmi_ack = 1'b0;
    check_val("nmi_ack", sr_if.nmi_req, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step(); check_val("nmi_low_no_retrig", sr_if.nmi_req, 8'h00);
    end
    sr_if.nmi_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check_val("nmi_high", sr_if.nmi_req, 8'h00);
    sr_if.nmi_n = 1'b0;
    step(); step();
    // The new edge is detected on the next edge, together with an ack.
    sr_if.nmi_ack = 1'b1;
    step(); sr_if.nmi_ack = 1'b0;
    check_val("nmi_edge_beats_ack", sr_if.nmi_req, 8'h01);
    sr_if.nmi_ack = 1'b1;
    step(); sr_if.nmi_ack = 1'b0;
    check_val("nmi_ack2", sr_if.nmi_req, 8'h00);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
